// File: rtl/int_mul_var_lat.sv
// Iterative shift-add multiplier returning the low p_nbits of op1*op2.
// Latency tracks the highest set bit of op2, so small multipliers finish early.
module int_mul_var_lat #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [2*p_nbits-1:0]   req_msg,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [p_nbits-1:0]     resp_msg,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [p_nbits-1:0] a_q;
  logic [p_nbits-1:0] b_q;
  logic [p_nbits-1:0] result_q;
  logic [5:0]         iter_q;

  logic [p_nbits-1:0] b_shift_d;
  logic [p_nbits-1:0] sum_d;
  logic               last_d;

  assign b_shift_d = b_q >> 1;
  assign sum_d     = b_q[0] ? (result_q + a_q) : result_q;
  // Stop once no multiplier bits remain, or after the final bit position.
  assign last_d    = (b_shift_d == '0) || (iter_q == 6'(p_nbits - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      iter_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_val) begin
            a_q      <= req_msg[p_nbits-1:0];
            b_q      <= req_msg[2*p_nbits-1:p_nbits];
            result_q <= '0;
            iter_q   <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          result_q <= sum_d;
          a_q      <= a_q << 1;
          b_q      <= b_shift_d;
          iter_q   <= iter_q + 6'd1;
          if (last_d) state_q <= DONE;
        end
        DONE: begin
          if (resp_rdy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from the state register.
  assign req_rdy  = (state_q == IDLE);
  assign resp_val = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign resp_msg = result_q;

endmodule
